// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer:
// FSM states, jump condition codes and flag bit positions.
package pc_sequencer_pkg;

   localparam int unsigned COND_W = 3;
   localparam int unsigned FLAG_W = 4;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WB     = 3'd3,
      ST_HALT   = 3'd4
   } state_t;

   localparam logic [COND_W-1:0] COND_Z      = 3'b000;
   localparam logic [COND_W-1:0] COND_LT     = 3'b001;
   localparam logic [COND_W-1:0] COND_LE     = 3'b010;
   localparam logic [COND_W-1:0] COND_NZ     = 3'b011;
   localparam logic [COND_W-1:0] COND_C      = 3'b100;
   localparam logic [COND_W-1:0] COND_NC     = 3'b101;
   localparam logic [COND_W-1:0] COND_ALWAYS = 3'b110;
   localparam logic [COND_W-1:0] COND_NEVER  = 3'b111;

   localparam int unsigned FLAG_S = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/pc_sequencer_cond_eval.sv
// Combinational jump-condition evaluator over the {S,Z,C,V} flag register.
module cond_eval
   import pc_sequencer_pkg::*;
(
   input  logic [COND_W-1:0] cond,
   input  logic [FLAG_W-1:0] flags,
   input  logic              enable,
   output logic              take
);

   logic lt;
   logic hit;

   always_comb begin
      lt  = flags[FLAG_S] ^ flags[FLAG_V];
      hit = 1'b0;
      case (cond)
         COND_Z:      hit = flags[FLAG_Z];
         COND_LT:     hit = lt;
         COND_LE:     hit = flags[FLAG_Z] | lt;
         COND_NZ:     hit = ~flags[FLAG_Z];
         COND_C:      hit = flags[FLAG_C];
         COND_NC:     hit = ~flags[FLAG_C];
         COND_ALWAYS: hit = 1'b1;
         COND_NEVER:  hit = 1'b0;
         default:     hit = 1'b0;
      endcase
      take = enable & hit;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/WB with a sticky HALT,
// flag register and conditional jumps resolved in write-back.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int unsigned PC_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   input  logic              halt_req,
   input  logic              flag_we,
   input  logic [FLAG_W-1:0] flag_in,
   input  logic              jump_req,
   input  logic [COND_W-1:0] jump_cond,
   input  logic [PC_W-1:0]   jump_target,
   output logic [PC_W-1:0]   pc,
   output logic              fetch_req,
   output logic              ir_load,
   output logic              exec_en,
   output logic              wb_en,
   output logic [FLAG_W-1:0] flags,
   output logic              taken,
   output logic              halted
);

   state_t            state;
   state_t            state_nxt;
   logic [PC_W-1:0]   pc_nxt;
   logic [FLAG_W-1:0] flags_nxt;
   logic              jump_take;

   // Jumps only resolve in WB, against the flags already registered at the end of EXEC.
   cond_eval u_cond_eval (
      .cond   (jump_cond),
      .flags  (flags),
      .enable (jump_req && (state == ST_WB)),
      .take   (jump_take)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_FETCH;
         pc    <= '0;
         flags <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         flags <= flags_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      flags_nxt = flags;
      fetch_req = 1'b0;
      ir_load   = 1'b0;
      exec_en   = 1'b0;
      wb_en     = 1'b0;
      taken     = 1'b0;
      halted    = 1'b0;
      case (state)
         ST_FETCH: begin
            fetch_req = 1'b1;
            ir_load   = instr_valid;
            if (instr_valid) state_nxt = ST_DECODE;
         end
         ST_DECODE: begin
            state_nxt = halt_req ? ST_HALT : ST_EXEC;
         end
         ST_EXEC: begin
            exec_en = 1'b1;
            if (flag_we) flags_nxt = flag_in;
            state_nxt = ST_WB;
         end
         ST_WB: begin
            wb_en     = 1'b1;
            taken     = jump_take;
            pc_nxt    = jump_take ? jump_target : pc + PC_W'(1);
            state_nxt = ST_FETCH;
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: state_nxt = ST_FETCH;
      endcase
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 16, program-counter width in bits.
REQ-002 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have instr_valid  input  1  instruction memory returns the fetched word this cycle.
REQ-005 SHALL have halt_req  input  1  the decoded instruction is HALT; sampled in DECODE.
REQ-006 SHALL have flag_we  input  1  the ALU result updates flags; sampled in EXEC.
REQ-007 SHALL have flag_in  input  4  new flags {S,Z,C,V}; sampled in EXEC.
REQ-008 SHALL have jump_req  input  1  the decoded instruction is a conditional jump; sampled in WB.
REQ-009 SHALL have jump_cond  input  3  condition code; sampled in WB.
REQ-010 SHALL have jump_target  input  PC_W  jump destination; sampled in WB.
REQ-011 SHALL have pc  output  PC_W  current program counter.
REQ-012 SHALL have fetch_req  output  1  request to instruction memory at address pc.
REQ-013 SHALL have ir_load  output  1  instruction-register load strobe.
REQ-014 SHALL have exec_en  output  1  ALU execute strobe.
REQ-015 SHALL have wb_en  output  1  register-file write-back strobe.
REQ-016 SHALL have flags  output  4  flag register {S,Z,C,V}.
REQ-017 SHALL have taken  output  1  one-cycle pulse when a jump is taken.
REQ-018 SHALL have halted  output  1  high while in HALT.

Function
REQ-019 SHALL implement the FSM states FETCH, DECODE, EXEC, WB and HALT, one state per cycle unless stated otherwise.
REQ-020 FETCH SHALL hold fetch_req=1 until instr_valid=1, then assert ir_load=1 in that same cycle and go to DECODE; with instr_valid=0 it SHALL stay in FETCH.
REQ-021 DECODE SHALL go to HALT if halt_req=1, otherwise to EXEC.
REQ-022 EXEC SHALL assert exec_en=1 for one cycle; if flag_we=1, flags SHALL load flag_in at the end of EXEC; then go to WB.
REQ-023 WB SHALL assert wb_en=1 for one cycle, update pc per REQ-024/REQ-025, and go to FETCH.
REQ-024 In WB, if jump_req=1 and the condition is true, the block SHALL set pc to jump_target and pulse taken=1 in the WB cycle.
REQ-025 In WB, otherwise, the block SHALL set pc to pc+1 modulo 2^PC_W, so all-ones wraps to 0.
REQ-026 Conditions SHALL evaluate the registered flags: 000 Z; 001 S^V; 010 Z|(S^V); 011 !Z; 100 C; 101 !C; 110 always; 111 never.
REQ-027 A flag update in EXEC SHALL be visible to the jump evaluation in the immediately following WB, with no stale-flag bubble.
REQ-028 HALT SHALL be sticky until rst: halted=1, all strobes 0, pc and flags frozen.
REQ-029 All strobes SHALL be Moore outputs of the state; the exception is ir_load, which is FETCH gated by instr_valid.
REQ-030 An instruction SHALL take 4 cycles with zero memory wait, plus one cycle per cycle instr_valid is low.

Reset
REQ-031 rst=1 SHALL immediately force: state FETCH, pc=0, flags=4'b0000, taken=0, halted=0.
REQ-032 The first fetch_req=1 SHALL appear in the first cycle after rst deasserts, at pc=0.
REQ-033 rst asserted mid-instruction, in any state including HALT, SHALL abort the instruction with no pc or flag update.

Structure
REQ-034 The shared package SHALL hold the state enumeration, the condition-code constants (COND_Z .. COND_NEVER) and the flag bit indices S=3, Z=2, C=1, V=0.
REQ-035 Condition evaluation SHALL live in one combinational sub-module, cond_eval (inputs cond, flags, enable; output take), instantiated once.

Verification
REQ-036 Reset then instr_valid held 1, no jumps, 3 instructions -> pc sequence 0,1,2,3; fetch_req/ir_load/exec_en/wb_en each high every 4th cycle.
REQ-037 instr_valid low for 3 cycles in FETCH -> FETCH held 3 extra cycles, pc unchanged, ir_load only on the valid cycle.
REQ-038 EXEC with flag_we=1 and flag_in=0100 (Z), then WB with jump_req=1, cond=000, target=0x0040 -> pc=0x0040 and taken pulses once; same case with cond=011 -> pc+1, taken=0.
REQ-039 flags S=1,V=0 with conds 001, 010 and 111 -> taken, taken, not taken; pc=0xFFFF with no jump -> pc wraps to 0x0000.
REQ-040 halt_req=1 in DECODE -> halted=1 and strobes 0 for 20 cycles; then rst pulse in mid-EXEC -> pc=0, flags=0, FETCH asserted right after release.
